// File: rtl/dwcv_ctrl.sv
// Sequencer for a depthwise-separable conv layer sharing one conv_layer engine:
// depthwise jobs per input channel, then pointwise jobs per output channel.
module dwcv_ctrl #(
    parameter int INPUT_CHANNELS  = 3,
    parameter int OUTPUT_CHANNELS = 3,
    parameter int TIMEOUT_CYCLES  = 1024,
    localparam int MAX_CH = (INPUT_CHANNELS > OUTPUT_CHANNELS)
                          ? ((INPUT_CHANNELS > 2) ? INPUT_CHANNELS : 2)
                          : ((OUTPUT_CHANNELS > 2) ? OUTPUT_CHANNELS : 2),
    localparam int CH_W = $clog2(MAX_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            eng_done,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic            eng_start,
    output logic            eng_mode,
    output logic [CH_W-1:0] eng_ch
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CH_W-1:0] DW_LAST = CH_W'(INPUT_CHANNELS - 1);
    localparam logic [CH_W-1:0] PW_LAST = CH_W'(OUTPUT_CHANNELS - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, DW_ISSUE, DW_WAIT, PW_ISSUE, PW_WAIT, FIN
    } state_t;

    state_t          state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            mode_q, mode_d;
    logic            error_q, error_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            eng_start_q, eng_start_d;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        wd_d    = wd_q;
        mode_d  = mode_q;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DW_ISSUE;
                    ch_d    = '0;
                    error_d = 1'b0;
                end
            end
            DW_ISSUE: begin
                state_d = DW_WAIT;
                wd_d    = '0;
            end
            PW_ISSUE: begin
                state_d = PW_WAIT;
                wd_d    = '0;
            end
            DW_WAIT, PW_WAIT: begin
                // A completion in the same cycle as the timeout still counts as success.
                if (eng_done) begin
                    if (state_q == DW_WAIT) begin
                        if (ch_q < DW_LAST) begin
                            ch_d    = ch_q + CH_W'(1);
                            state_d = DW_ISSUE;
                        end else begin
                            ch_d    = '0;
                            state_d = PW_ISSUE;
                        end
                    end else begin
                        if (ch_q < PW_LAST) begin
                            ch_d    = ch_q + CH_W'(1);
                            state_d = PW_ISSUE;
                        end else begin
                            state_d = FIN;
                        end
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST)) begin
                    error_d = 1'b1;
                    state_d = FIN;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            ch_d    = '0;
            error_d = error_q;
        end

        if (state_d == DW_ISSUE) mode_d = 1'b0;
        if (state_d == PW_ISSUE) mode_d = 1'b1;

        eng_start_d = (state_d == DW_ISSUE) || (state_d == PW_ISSUE);
        busy_d      = eng_start_d || (state_d == DW_WAIT) || (state_d == PW_WAIT);
        done_d      = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            wd_q        <= '0;
            mode_q      <= 1'b0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            eng_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            wd_q        <= wd_d;
            mode_q      <= mode_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            eng_start_q <= eng_start_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign eng_start = eng_start_q;
    assign eng_mode  = mode_q;
    assign eng_ch    = ch_q;

endmodule

// File: tb/tb_dwcv_ctrl.sv
// Directed bench for dwcv_ctrl: default instance plus a short-watchdog instance.
module tb_dwcv_ctrl;

    logic clk = 1'b0;
    logic rst_n, start, abort, eng_done;
    always #5 clk = ~clk;

    logic       b1, d1, e1, s1, m1, b2, d2, e2, s2, m2;
    logic [1:0] c1, c2;

    dwcv_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .eng_done(eng_done),
        .busy(b1), .done(d1), .error(e1), .eng_start(s1), .eng_mode(m1), .eng_ch(c1)
    );

    dwcv_ctrl #(.TIMEOUT_CYCLES(4)) u_dut_wd (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .eng_done(eng_done),
        .busy(b2), .done(d2), .error(e2), .eng_start(s2), .eng_mode(m2), .eng_ch(c2)
    );

    logic       sel;
    logic       o_busy, o_done, o_error, o_start, o_mode;
    logic [1:0] o_ch;
    always_comb begin
        o_busy  = sel ? b2 : b1;
        o_done  = sel ? d2 : d1;
        o_error = sel ? e2 : e1;
        o_start = sel ? s2 : s1;
        o_mode  = sel ? m2 : m1;
        o_ch    = sel ? c2 : c1;
    end

    int checks = 0;
    int failures = 0;
    int cyc, last_issue, n_starts, done_cyc;
    logic err_done, err_first;
    int   st_cyc [8];
    logic st_mode[8];
    int   st_ch  [8];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Engine model: eng_done rises 'delay' cycles after each eng_start cycle.
    task automatic run(input int delay, input int abort_at, input int ign_start_at,
                       input int spur_at, input int reset_at);
        start = 1'b1; abort = 1'b0; eng_done = (spur_at == 0);
        cyc = 0; last_issue = -1000; n_starts = 0; done_cyc = -1;
        err_done = 1'b0; err_first = 1'bx;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (o_start) begin
                if (n_starts < 8) begin
                    st_cyc[n_starts]  = cyc;
                    st_mode[n_starts] = o_mode;
                    st_ch[n_starts]   = int'(o_ch);
                end
                if (n_starts == 0) err_first = o_error;
                n_starts++;
                last_issue = cyc;
            end
            if (o_done) begin
                done_cyc = cyc;
                err_done = o_error;
            end
            start    = (cyc == ign_start_at);
            abort    = (cyc == abort_at);
            eng_done = (cyc == last_issue + delay) || (cyc == spur_at);
            if (cyc == reset_at) begin
                chk("pre_reset_ch", int'(o_ch), 1);
                #2 rst_n = 1'b0;
                #1;
                chk("async_rst_busy", int'(o_busy), 0);
                chk("async_rst_ch", int'(o_ch), 0);
                chk("async_rst_start", int'(o_start), 0);
                break;
            end
            if (done_cyc >= 0 || cyc == abort_at + 1) break;
        end
        start = 1'b0; abort = 1'b0; eng_done = 1'b0;
    endtask

    initial begin
        sel = 1'b0; rst_n = 1'b0; start = 1'b0; abort = 1'b0; eng_done = 1'b0;
        #2;
        chk("rst_busy", int'(b1), 0);
        chk("rst_done", int'(d1), 0);
        chk("rst_error", int'(e1), 0);
        chk("rst_eng_start", int'(s1), 0);
        chk("rst_mode", int'(m1), 0);
        chk("rst_ch", int'(c1), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Nominal run, completion on first WAIT cycle.
        run(1, -10, -10, -10, -10);
        chk("nom_starts", n_starts, 6);
        for (int i = 0; i < 6; i++) begin
            chk("nom_start_cyc", st_cyc[i], 1 + 2 * i);
            chk("nom_mode", int'(st_mode[i]), (i >= 3) ? 1 : 0);
            chk("nom_ch", st_ch[i], i % 3);
        end
        chk("nom_done_cyc", done_cyc, 13);
        chk("nom_error", int'(err_done), 0);
        tick();
        chk("nom_done_pulse", int'(o_done), 0);
        chk("nom_idle_busy", int'(o_busy), 0);

        // Engine 5 cycles late, start at cycle 10 must be ignored.
        run(5, -10, 10, -10, -10);
        chk("slow_done_cyc", done_cyc, 37);
        chk("slow_starts", n_starts, 6);
        tick();
        chk("slow_no_rerun", int'(o_busy), 0);

        // Spurious eng_done in IDLE and in an ISSUE cycle.
        eng_done = 1'b1;
        repeat (3) tick();
        chk("spur_idle_busy", int'(o_busy), 0);
        chk("spur_idle_start", int'(o_start), 0);
        eng_done = 1'b0;
        run(2, -10, -10, 4, -10);
        chk("spur_starts", n_starts, 6);
        chk("spur_done_cyc", done_cyc, 19);
        tick();

        // Abort during PW_WAIT of job 4 (with eng_done also high).
        run(1, 8, -10, -10, -10);
        chk("abort_busy", int'(o_busy), 0);
        chk("abort_ch", int'(o_ch), 0);
        chk("abort_done", int'(o_done), 0);
        chk("abort_eng_start", int'(o_start), 0);
        chk("abort_no_done_seen", done_cyc, -1);
        chk("abort_starts", n_starts, 4);
        repeat (3) tick();
        chk("abort_idle_done", int'(o_done), 0);
        run(1, -10, -10, -10, -10);
        chk("rerun_first_cyc", st_cyc[0], 1);
        chk("rerun_first_mode", int'(st_mode[0]), 0);
        chk("rerun_first_ch", st_ch[0], 0);
        chk("rerun_done_cyc", done_cyc, 13);
        tick();

        // Watchdog on the TIMEOUT_CYCLES=4 instance; engine never answers.
        sel = 1'b1;
        run(1000, -10, -10, -10, -10);
        chk("wd_starts", n_starts, 1);
        chk("wd_start_cyc", st_cyc[0], 1);
        chk("wd_done_cyc", done_cyc, 6);
        chk("wd_error", int'(err_done), 1);
        tick();
        chk("wd_error_sticky", int'(o_error), 1);
        chk("wd_done_pulse", int'(o_done), 0);
        run(1, -10, -10, -10, -10);
        chk("wd_error_cleared", int'(err_first), 0);
        chk("wd_rerun_done_cyc", done_cyc, 13);
        chk("wd_rerun_error", int'(err_done), 0);
        tick();
        sel = 1'b0;

        // Asynchronous reset in DW_WAIT of job 2.
        run(5, -10, -10, -10, 8);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_busy", int'(o_busy), 0);
        chk("post_rst_done", int'(o_done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
